// File: rtl/serpent_subkey_store.sv
// Serpent round-subkey store: collects NUM_KEYS 128-bit subkeys from the key schedule,
// then serves single-cycle-latency reads to the round engine once every index is written.
module serpent_subkey_store #(
  parameter int unsigned NUM_KEYS = 33,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clear,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [127:0]      i_wr_data,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [127:0]      o_rd_data,
  output logic              o_rd_valid,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_err
);

  localparam logic [ADDR_W:0] KeyLimit = (ADDR_W + 1)'(NUM_KEYS);

  typedef enum logic [1:0] {StEmpty, StLoading, StReady} state_e;

  state_e              state_q;
  logic [NUM_KEYS-1:0] bitmap_q, bitmap_d;
  logic [127:0]        mem_q [NUM_KEYS];
  logic [ADDR_W-1:0]   count_q;
  logic [127:0]        rd_data_q;
  logic                rd_valid_q, err_q, ready_q;

  logic wr_in_range, rd_in_range, wr_ok, wr_new, rd_ok, rd_bad, load_done;

  always_comb begin
    wr_in_range = {1'b0, i_wr_addr} < KeyLimit;
    rd_in_range = {1'b0, i_rd_addr} < KeyLimit;
    wr_ok       = i_wr_en && wr_in_range && (state_q != StReady) && !i_clear;
    wr_new      = wr_ok && !bitmap_q[i_wr_addr];
    bitmap_d    = bitmap_q;
    if (wr_ok) bitmap_d[i_wr_addr] = 1'b1;
    load_done   = &bitmap_d;
    rd_ok       = i_rd_req && (state_q == StReady) && rd_in_range;
    rd_bad      = i_rd_req && (state_q == StReady) && !rd_in_range;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= StEmpty;
      bitmap_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else if (i_clear) begin
      // Clear wins over any simultaneous write or read; read data register is left as is.
      state_q    <= StEmpty;
      bitmap_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) rd_data_q <= mem_q[i_rd_addr];
      if ((i_wr_en && !wr_ok) || rd_bad) err_q <= 1'b1;
      if (wr_ok) begin
        bitmap_q <= bitmap_d;
        if (wr_new) count_q <= count_q + ADDR_W'(1);
        if (load_done) begin
          state_q <= StReady;
          ready_q <= 1'b1;
        end else begin
          state_q <= StLoading;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NUM_KEYS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_ready    = ready_q;
  assign o_count    = count_q;
  assign o_err      = err_q;

endmodule
